instruction_fetch: RTL and testbench

Fetch stage between the Hack program counter and the instruction ROM. Captures the current PC value, issues one read at a time to a variable-latency ROM port, and buffers returned instructions with their addresses in a small FIFO for the decode stage. Drives the PC's `inc` input so the PC advances only when a fetch is accepted, and discards all in-flight and buffered work when a jump is taken.

---
 rtl/instruction_fetch.sv | 151 +++++++++++++++
 tb/tb_instruction_fetch.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage between the Hack PC and a variable-latency instruction ROM.
// Issues one read at a time and queues {address, instruction} pairs for decode.
module instruction_fetch #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       pc_addr_i,
  input  logic              jump_i,
  output logic              pc_inc_o,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_gnt_i,
  input  logic              rom_rvalid_i,
  input  logic [15:0]       rom_data_i,
  output logic [15:0]       instr_o,
  output logic [15:0]       instr_addr_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  // One spare bit so occupancy plus outstanding never wraps.
  typedef logic [CntW:0] cnt_t;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e             state_q, state_d;
  logic [15:0]        req_addr_q, req_addr_d;
  logic               drop_q, drop_d;
  logic [15:0]        data_q [DEPTH];
  logic [15:0]        data_d [DEPTH];
  logic [15:0]        addr_q [DEPTH];
  logic [15:0]        addr_d [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;

  cnt_t count;
  cnt_t wr_idx;
  logic outstanding, credit, room_after, pop, push;

  always_comb begin
    count = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count = count + cnt_t'(vld_q[i]);
    end
  end

  assign pop         = vld_q[0] & instr_ready_i;
  assign outstanding = (state_q != StIdle);
  assign credit      = (count + cnt_t'(outstanding)) < cnt_t'(DEPTH);
  assign room_after  = (count + cnt_t'(1) - cnt_t'(pop)) < cnt_t'(DEPTH);
  assign wr_idx      = count - cnt_t'(pop);

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;
    push       = 1'b0;
    rom_req_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (credit && !jump_i) begin
          req_addr_d = pc_addr_i;
          state_d    = StReq;
        end
      end
      StReq: begin
        rom_req_o = 1'b1;
        if (rom_gnt_i) begin
          // A jump racing the grant leaves one response to swallow.
          drop_d  = jump_i;
          state_d = StWait;
        end else if (jump_i) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (rom_rvalid_i) begin
          drop_d  = 1'b0;
          state_d = StIdle;
          if (!drop_q && !jump_i) begin
            push = 1'b1;
            if (room_after) begin
              req_addr_d = pc_addr_i;
              state_d    = StReq;
            end
          end
        end else if (jump_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign pc_inc_o   = rom_req_o & rom_gnt_i & ~jump_i;
  assign rom_addr_o = req_addr_q[ADDR_W-1:0];

  // Shift-register FIFO: entry 0 is the head, so the outputs come straight from flops.
  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    vld_d  = vld_q;
    if (pop) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        data_d[i] = data_q[i+1];
        addr_d[i] = addr_q[i+1];
        vld_d[i]  = vld_q[i+1];
      end
      vld_d[DEPTH-1] = 1'b0;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push && (cnt_t'(i) == wr_idx)) begin
        data_d[i] = rom_data_i;
        addr_d[i] = req_addr_q;
        vld_d[i]  = 1'b1;
      end
    end
    if (jump_i) begin
      vld_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      req_addr_q <= '0;
      drop_q     <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      vld_q      <= vld_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= data_d[i];
        addr_q[i] <= addr_d[i];
      end
    end
  end

  assign instr_o       = data_q[0];
  assign instr_addr_o  = addr_q[0];
  assign instr_valid_o = vld_q[0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: PC and ROM models plus a program-order stream scoreboard.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [15:0] pc_addr_i;
  logic        jump_i;
  logic        pc_inc_o;
  logic        rom_req_o;
  logic [14:0] rom_addr_o;
  logic        rom_gnt_i;
  logic        rom_rvalid_i;
  logic [15:0] rom_data_i;
  logic [15:0] instr_o;
  logic [15:0] instr_addr_o;
  logic        instr_valid_o;
  logic        instr_ready_i;

  instruction_fetch #(
    .DEPTH (2),
    .ADDR_W(15)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .pc_addr_i    (pc_addr_i),
    .jump_i       (jump_i),
    .pc_inc_o     (pc_inc_o),
    .rom_req_o    (rom_req_o),
    .rom_addr_o   (rom_addr_o),
    .rom_gnt_i    (rom_gnt_i),
    .rom_rvalid_i (rom_rvalid_i),
    .rom_data_i   (rom_data_i),
    .instr_o      (instr_o),
    .instr_addr_o (instr_addr_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total, n_bad;
  int cyc, rel, since_jump, n_inc, n_dlv;
  int ready_pct, gnt_pct, lat_min, lat_max;
  logic [15:0] pc_q, exp_addr;
  logic        pend;
  logic [14:0] pend_addr;
  int          due;
  logic        p_rst, p_req, p_gnt, p_jmp, p_valid, p_ready;
  logic [14:0] p_addr;
  logic [15:0] p_instr, p_iaddr;
  logic        last_grant;
  logic [14:0] last_grant_addr;
  logic        s_req, s_inc, s_valid;
  logic [14:0] s_addr;
  int          dq_cyc[$];
  logic [15:0] dq_addr[$];
  logic [15:0] dq_data[$];
  logic [14:0] gq[$];

  function automatic logic [15:0] rom_word(input logic [14:0] a);
    return 16'h1000 + {1'b0, a};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check, then advance the models.
  task automatic step(input logic jmp, input logic [15:0] tgt, input logic rst);
    logic rv, grant, dlv;
    @(negedge clk);
    reset         = rst;
    jump_i        = jmp;
    pc_addr_i     = pc_q;
    instr_ready_i = ($urandom_range(99) < ready_pct);
    rom_gnt_i     = rom_req_o && ($urandom_range(99) < gnt_pct);
    rv            = pend && (due == cyc);
    rom_rvalid_i  = rv;
    rom_data_i    = rv ? rom_word(pend_addr) : 16'($urandom);
    #1;
    grant   = rom_req_o & rom_gnt_i;
    dlv     = instr_valid_o & instr_ready_i;
    s_req   = rom_req_o;
    s_addr  = rom_addr_o;
    s_inc   = pc_inc_o;
    s_valid = instr_valid_o;
    if (!rst) begin
      if (p_rst) begin
        check_eq("rst_req", 32'(rom_req_o), 0);
        check_eq("rst_inc", 32'(pc_inc_o), 0);
        check_eq("rst_valid", 32'(instr_valid_o), 0);
        check_eq("rst_instr", 32'(instr_o), 0);
        check_eq("rst_iaddr", 32'(instr_addr_o), 0);
        check_eq("rst_raddr", 32'(rom_addr_o), 0);
      end
      check_eq("pc_inc", 32'(pc_inc_o), 32'(rom_req_o & rom_gnt_i & ~jmp));
      if (!p_rst && p_req && !p_gnt && !p_jmp) begin
        check_eq("req_hold", 32'(rom_req_o), 1);
        check_eq("addr_hold", 32'(rom_addr_o), 32'(p_addr));
      end
      if (grant) begin
        check_eq("fetch_addr", 32'(rom_addr_o), 32'(pc_q[14:0]));
        check_eq("one_out", 32'(pend), 0);
      end
      if (dlv) begin
        check_eq("dlv_addr", 32'(instr_addr_o), 32'(exp_addr));
        check_eq("dlv_data", 32'(instr_o), 32'(rom_word(exp_addr[14:0])));
      end
      if (!p_rst && p_valid && !p_ready && !p_jmp) begin
        check_eq("hold_valid", 32'(instr_valid_o), 1);
        check_eq("hold_instr", 32'(instr_o), 32'(p_instr));
        check_eq("hold_iaddr", 32'(instr_addr_o), 32'(p_iaddr));
      end
      if (since_jump >= 1 && since_jump < 4) begin
        check_eq("flush_gap", 32'(instr_valid_o), 0);
      end
    end
    p_rst   = rst;
    p_req   = rom_req_o;
    p_gnt   = rom_gnt_i;
    p_jmp   = jmp;
    p_addr  = rom_addr_o;
    p_valid = instr_valid_o;
    p_ready = instr_ready_i;
    p_instr = instr_o;
    p_iaddr = instr_addr_o;
    last_grant = grant;
    if (grant) last_grant_addr = rom_addr_o;
    if (rst) begin
      pc_q       = '0;
      pend       = 1'b0;
      exp_addr   = '0;
      rel        = 0;
      since_jump = 100;
    end else begin
      if (rv) pend = 1'b0;
      if (grant) begin
        pend      = 1'b1;
        pend_addr = rom_addr_o;
        due       = cyc + int'($urandom_range(lat_max, lat_min));
        gq.push_back(rom_addr_o);
      end
      if (pc_inc_o) n_inc++;
      if (dlv) begin
        dq_cyc.push_back(rel);
        dq_addr.push_back(instr_addr_o);
        dq_data.push_back(instr_o);
        exp_addr = exp_addr + 16'd1;
        n_dlv++;
      end
      if (jmp) begin
        pc_q       = tgt;
        exp_addr   = tgt;
        since_jump = 1;
      end else begin
        pc_q = pc_q + 16'(pc_inc_o);
        if (since_jump < 100) since_jump++;
      end
      rel++;
    end
    cyc++;
  endtask

  task automatic clear_logs();
    dq_cyc.delete();
    dq_addr.delete();
    dq_data.delete();
    gq.delete();
    n_inc = 0;
  endtask

  task automatic do_reset();
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    clear_logs();
  endtask

  task automatic run_until_grant(input logic [14:0] a, output logic found);
    int i;
    i     = 0;
    found = 1'b0;
    while (!found && i < 40) begin
      step(1'b0, 16'h0, 1'b0);
      found = last_grant && (last_grant_addr == a);
      i++;
    end
  endtask

  initial begin
    logic        found;
    logic [14:0] held;
    int          r;
    reset = 1'b1; jump_i = 1'b0; pc_addr_i = '0; rom_gnt_i = 1'b0;
    rom_rvalid_i = 1'b0; rom_data_i = '0; instr_ready_i = 1'b0;
    n_total = 0; n_bad = 0; cyc = 0; rel = 0; since_jump = 100; n_inc = 0; n_dlv = 0;
    pc_q = '0; exp_addr = '0; pend = 1'b0; pend_addr = '0; due = 0;
    p_rst = 1'b1; p_req = 1'b0; p_gnt = 1'b0; p_jmp = 1'b0; p_valid = 1'b0; p_ready = 1'b0;
    p_addr = '0; p_instr = '0; p_iaddr = '0; last_grant = 1'b0; last_grant_addr = '0;

    // Best-case latency and throughput with a 1-cycle ROM.
    ready_pct = 100; gnt_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    repeat (8) step(1'b0, 16'h0, 1'b0);
    check_eq("t1_count", 32'(dq_cyc.size() >= 3), 1);
    if (dq_cyc.size() >= 3) begin
      check_eq("t1_first_cyc", 32'(dq_cyc[0]), 3);
      check_eq("t1_second_cyc", 32'(dq_cyc[1]), 5);
      check_eq("t1_third_cyc", 32'(dq_cyc[2]), 7);
      check_eq("t1_d0", 32'(dq_data[0]), 32'h1000);
      check_eq("t1_d2", 32'(dq_data[2]), 32'h1002);
      check_eq("t1_a2", 32'(dq_addr[2]), 32'h0002);
    end
    check_eq("t1_inc", 32'(n_inc), 4);

    // Backpressure: two buffered, fetch stalls, then resumes at address 2.
    ready_pct = 0;
    do_reset();
    repeat (10) step(1'b0, 16'h0, 1'b0);
    check_eq("t2_pc", 32'(pc_q), 2);
    check_eq("t2_req", 32'(s_req), 0);
    check_eq("t2_inc", 32'(n_inc), 2);
    check_eq("t2_valid", 32'(s_valid), 1);
    check_eq("t2_instr", 32'(instr_o), 32'h1000);
    ready_pct = 100;
    clear_logs();
    repeat (10) step(1'b0, 16'h0, 1'b0);
    check_eq("t2_resume", 32'(dq_data.size() >= 1 && gq.size() >= 1), 1);
    if (dq_data.size() >= 1 && gq.size() >= 1) begin
      check_eq("t2_pop", 32'(dq_data[0]), 32'h1000);
      check_eq("t2_gaddr", 32'(gq[0]), 2);
    end

    // Jump while waiting for the response to address 3.
    lat_min = 2; lat_max = 2;
    do_reset();
    run_until_grant(15'd3, found);
    check_eq("t3_found", 32'(found), 1);
    step(1'b1, 16'h0040, 1'b0);
    clear_logs();
    repeat (20) step(1'b0, 16'h0, 1'b0);
    check_eq("t3_count", 32'(dq_addr.size() >= 1), 1);
    if (dq_addr.size() >= 1) begin
      check_eq("t3_addr", 32'(dq_addr[0]), 32'h0040);
      check_eq("t3_data", 32'(dq_data[0]), 32'h1040);
    end

    // Jump in the same cycle as rvalid.
    lat_min = 1; lat_max = 1;
    do_reset();
    run_until_grant(15'd2, found);
    check_eq("t4_found", 32'(found), 1);
    step(1'b1, 16'h0123, 1'b0);
    clear_logs();
    repeat (20) step(1'b0, 16'h0, 1'b0);
    check_eq("t4_count", 32'(dq_addr.size() >= 1), 1);
    if (dq_addr.size() >= 1) begin
      check_eq("t4_addr", 32'(dq_addr[0]), 32'h0123);
      check_eq("t4_data", 32'(dq_data[0]), 32'h1123);
    end

    // Grant withheld for several cycles.
    gnt_pct = 0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 16'h0, 1'b0);
      found = s_req;
    end
    check_eq("t5_req", 32'(found), 1);
    held = s_addr;
    repeat (5) begin
      step(1'b0, 16'h0, 1'b0);
      check_eq("t5_hold_req", 32'(s_req), 1);
      check_eq("t5_hold_addr", 32'(s_addr), 32'(held));
      check_eq("t5_no_inc", 32'(s_inc), 0);
    end
    gnt_pct = 100;
    step(1'b0, 16'h0, 1'b0);
    check_eq("t5_inc", 32'(s_inc), 1);
    step(1'b0, 16'h0, 1'b0);
    check_eq("t5_single", 32'(s_inc), 0);
    check_eq("t5_total_inc", 32'(n_inc), 1);

    // Reset during WAIT with one buffered entry.
    lat_min = 2; lat_max = 2; ready_pct = 0;
    do_reset();
    run_until_grant(15'd1, found);
    check_eq("t6_found", 32'(found), 1);
    check_eq("t6_buf", 32'(s_valid), 1);
    step(1'b0, 16'h0, 1'b1);
    clear_logs();
    ready_pct = 100;
    step(1'b0, 16'h0, 1'b0);
    check_eq("t6_valid", 32'(s_valid), 0);
    check_eq("t6_req", 32'(s_req), 0);
    repeat (8) step(1'b0, 16'h0, 1'b0);
    check_eq("t6_restart", 32'(gq.size() >= 1 && dq_addr.size() >= 1), 1);
    if (gq.size() >= 1 && dq_addr.size() >= 1) begin
      check_eq("t6_gaddr", 32'(gq[0]), 0);
      check_eq("t6_daddr", 32'(dq_addr[0]), 0);
    end

    // Randomized traffic with jumps, stalls and occasional resets.
    ready_pct = 70; gnt_pct = 60; lat_min = 1; lat_max = 3;
    do_reset();
    n_dlv = 0;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(999));
      if (r < 3) begin
        step(1'b0, 16'h0, 1'b1);
      end else if (r < 33) begin
        step(1'b1, ($urandom_range(3) == 0) ? 16'hFFFE : 16'($urandom), 1'b0);
      end else begin
        step(1'b0, 16'h0, 1'b0);
      end
    end
    check_eq("progress", 32'(n_dlv > 200), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
